// File: rtl/floo_id_dest_tracker.sv
// floo_id_dest_tracker
//   Sits on the AX side of the chimney request path, just upstream of the simple
//   reorder buffer. For each AXI ID it tracks the number of outstanding
//   transactions, how many of them were tagged for reordering, and the
//   destination the ID is currently bound to. Each AX request is tagged with
//   ax_rob_req_o, which says whether its response has to go through the ROB.
//   Entries are retired by watching last-beat handshakes on the response path.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ax_valid_i/ready_o   AX handshake from the initiator side
//   ax_id_i, ax_dest_i   ID and destination of the AX request
//   ax_valid_o/ready_i   AX handshake towards the reorder buffer (pass-through)
//   ax_rob_req_o         response must be reordered (qualified by ax_valid_o)
//   rsp_valid_i/ready_i  response handshake, observed only
//   rsp_id_i             response ID
//   rsp_rob_req_i        response was routed through the ROB
//   rsp_last_i           last beat of the response
//   busy_o               some ID has outstanding transactions
module floo_id_dest_tracker #(
  parameter int unsigned NumIds       = 16,
  parameter int unsigned MaxTxnsPerId = 8,
  parameter type         dest_t       = logic,
  parameter type         id_t         = logic [$clog2(NumIds)-1:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  ax_valid_i,
  output logic  ax_ready_o,
  input  id_t   ax_id_i,
  input  dest_t ax_dest_i,
  output logic  ax_valid_o,
  input  logic  ax_ready_i,
  output logic  ax_rob_req_o,
  input  logic  rsp_valid_i,
  input  logic  rsp_ready_i,
  input  id_t   rsp_id_i,
  input  logic  rsp_rob_req_i,
  input  logic  rsp_last_i,
  output logic  busy_o
);

  localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

  cnt_t  cnt_q     [NumIds];
  cnt_t  cnt_d     [NumIds];
  cnt_t  rob_cnt_q [NumIds];
  cnt_t  rob_cnt_d [NumIds];
  dest_t dest_q    [NumIds];
  dest_t dest_d    [NumIds];

  cnt_t  ax_cnt;
  cnt_t  ax_rob_cnt;
  dest_t ax_bound;
  logic  stall;
  logic  issue;
  logic  retire;

  assign ax_cnt     = cnt_q[ax_id_i];
  assign ax_rob_cnt = rob_cnt_q[ax_id_i];
  assign ax_bound   = dest_q[ax_id_i];

  // Decisions use registered state only: a retire in the same cycle frees a
  // full ID one cycle later, and ax_valid_o never looks at ax_ready_i.
  assign stall        = ax_valid_i && (ax_cnt == CntMax);
  assign ax_valid_o   = ax_valid_i && !stall;
  assign ax_ready_o   = ax_valid_i && ax_ready_i && !stall;
  // A free ID rebinds without reordering; a busy ID stays in order only when the
  // destination matches and no ROB-tagged predecessor is still pending.
  assign ax_rob_req_o = (ax_cnt != '0) && ((ax_bound != ax_dest_i) || (ax_rob_cnt != '0));

  assign issue  = ax_valid_o && ax_ready_i;
  assign retire = rsp_valid_i && rsp_ready_i && rsp_last_i;

  always_comb begin
    for (int unsigned i = 0; i < NumIds; i++) begin
      cnt_d[i]     = cnt_q[i];
      rob_cnt_d[i] = rob_cnt_q[i];
      dest_d[i]    = dest_q[i];
    end
    if (issue) begin
      cnt_d[ax_id_i] = ax_cnt + cnt_t'(1);
      if (ax_rob_req_o) rob_cnt_d[ax_id_i] = ax_rob_cnt + cnt_t'(1);
      if (ax_cnt == '0) dest_d[ax_id_i] = ax_dest_i;
    end
    // Decrement on top of the issue result so a same-ID issue/retire nets out.
    // Retiring an empty counter is a protocol error; the counter holds at zero.
    if (retire) begin
      if (cnt_q[rsp_id_i] != '0) cnt_d[rsp_id_i] = cnt_d[rsp_id_i] - cnt_t'(1);
      if (rsp_rob_req_i && (rob_cnt_q[rsp_id_i] != '0)) begin
        rob_cnt_d[rsp_id_i] = rob_cnt_d[rsp_id_i] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i]     <= '0;
        rob_cnt_q[i] <= '0;
        dest_q[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i]     <= cnt_d[i];
        rob_cnt_q[i] <= rob_cnt_d[i];
        dest_q[i]    <= dest_d[i];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (cnt_q[i] != '0) busy_o = 1'b1;
    end
  end

`ifndef SYNTHESIS
  retire_on_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire |-> (cnt_q[rsp_id_i] != '0));
  rob_retire_on_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (retire && rsp_rob_req_i) |-> (rob_cnt_q[rsp_id_i] != '0));
  for (genvar g = 0; g < NumIds; g++) begin : gen_inv
    rob_le_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rob_cnt_q[g] <= cnt_q[g]);
  end
`endif

endmodule

// File: tb/tb_floo_id_dest_tracker.sv
// Self-checking bench for floo_id_dest_tracker. Expected rob_req tags are pushed
// to a scoreboard queue as each request is driven and popped when the DUT shows
// the corresponding AX handshake. Outstanding counts are checked through their
// visible effects: busy_o, the stall boundary and later rob_req decisions.
module tb_floo_id_dest_tracker;

  typedef logic [3:0] id_t;
  typedef logic [3:0] dest_t;

  localparam dest_t DA = 4'hA;
  localparam dest_t DB = 4'hB;
  localparam dest_t DC = 4'hC;

  logic  clk;
  logic  rst_n;
  logic  ax_valid_i;
  logic  ax_ready_o;
  id_t   ax_id_i;
  dest_t ax_dest_i;
  logic  ax_valid_o;
  logic  ax_ready_i;
  logic  ax_rob_req_o;
  logic  rsp_valid_i;
  logic  rsp_ready_i;
  id_t   rsp_id_i;
  logic  rsp_rob_req_i;
  logic  rsp_last_i;
  logic  busy_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic obs_valid;
  logic obs_ready;
  logic obs_rob;
  logic exp_rob;
  logic sb[$];

  floo_id_dest_tracker #(
    .NumIds      (16),
    .MaxTxnsPerId(8),
    .dest_t      (dest_t),
    .id_t        (id_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ax_valid_i   (ax_valid_i),
    .ax_ready_o   (ax_ready_o),
    .ax_id_i      (ax_id_i),
    .ax_dest_i    (ax_dest_i),
    .ax_valid_o   (ax_valid_o),
    .ax_ready_i   (ax_ready_i),
    .ax_rob_req_o (ax_rob_req_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_i     (rsp_id_i),
    .rsp_rob_req_i(rsp_rob_req_i),
    .rsp_last_i   (rsp_last_i),
    .busy_o       (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    ax_valid_i    = 1'b0;
    ax_id_i       = '0;
    ax_dest_i     = '0;
    ax_ready_i    = 1'b0;
    rsp_valid_i   = 1'b0;
    rsp_ready_i   = 1'b0;
    rsp_id_i      = '0;
    rsp_rob_req_i = 1'b0;
    rsp_last_i    = 1'b0;
  endtask

  // One clock of stimulus; outputs are sampled on the falling edge.
  task automatic step(input logic v, input id_t id, input dest_t dest, input logic rdy,
                      input logic rv, input logic rr, input id_t rid, input logic rrob,
                      input logic rlast);
    ax_valid_i    = v;
    ax_id_i       = id;
    ax_dest_i     = dest;
    ax_ready_i    = rdy;
    rsp_valid_i   = rv;
    rsp_ready_i   = rr;
    rsp_id_i      = rid;
    rsp_rob_req_i = rrob;
    rsp_last_i    = rlast;
    @(negedge clk);
    obs_valid = ax_valid_o;
    obs_ready = ax_ready_o;
    obs_rob   = ax_rob_req_o;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic issue_step(input id_t id, input dest_t dest);
    step(1'b1, id, dest, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic retire_step(input id_t rid, input logic rrob);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, rid, rrob, 1'b1);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ax_ready_o !== 1'b0) $display("FAIL reset ax_ready_o: got %b want 0", ax_ready_o);
    else n_pass++;
    n_checks++;
    if (ax_valid_o !== 1'b0) $display("FAIL reset ax_valid_o: got %b want 0", ax_valid_o);
    else n_pass++;
    n_checks++;
    if (ax_rob_req_o !== 1'b0) $display("FAIL reset ax_rob_req_o: got %b want 0", ax_rob_req_o);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL reset busy_o: got %b want 0", busy_o);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    for (int k = 0; k < 3; k++) begin
      sb.push_back(1'b0);
      issue_step(4'd3, DA);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready))
        $display("FAIL bypass handshake %0d: got %b/%b want 1/1", k, obs_valid, obs_ready);
      else if (obs_rob !== exp_rob)
        $display("FAIL bypass rob_req %0d: got %b want %b", k, obs_rob, exp_rob);
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL bypass busy_o: got %b want 1", busy_o);
        else n_pass++;
      end
    end
    retire_step(4'd3, 1'b0);
  endtask

  // ID 3 holds two untagged requests bound to DA on entry.
  task automatic test_rob_tag();
    dest_t d1 [2] = '{DB, DA};
    logic  e1 [2] = '{1'b1, 1'b1};
    dest_t d2 [2] = '{DA, DB};
    logic  e2 [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      sb.push_back(e1[k]);
      issue_step(4'd3, d1[k]);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready))
        $display("FAIL rob_tag handshake %0d: got %b/%b want 1/1", k, obs_valid, obs_ready);
      else if (obs_rob !== exp_rob)
        $display("FAIL rob_tag rob_req %0d: got %b want %b", k, obs_rob, exp_rob);
      else n_pass++;
    end
    retire_step(4'd3, 1'b1);
    retire_step(4'd3, 1'b1);
    // No ROB predecessor left: DA must still be the bound destination.
    for (int k = 0; k < 2; k++) begin
      sb.push_back(e2[k]);
      issue_step(4'd3, d2[k]);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready))
        $display("FAIL rebound handshake %0d: got %b/%b want 1/1", k, obs_valid, obs_ready);
      else if (obs_rob !== exp_rob)
        $display("FAIL rebound rob_req %0d: got %b want %b", k, obs_rob, exp_rob);
      else n_pass++;
    end
    retire_step(4'd3, 1'b1);
    for (int k = 0; k < 3; k++) retire_step(4'd3, 1'b0);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL rob_tag drain busy_o: got %b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 8; k++) begin
      sb.push_back(1'b0);
      issue_step(4'd5, DA);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready))
        $display("FAIL fill handshake %0d: got %b/%b want 1/1", k, obs_valid, obs_ready);
      else if (obs_rob !== exp_rob)
        $display("FAIL fill rob_req %0d: got %b want %b", k, obs_rob, exp_rob);
      else n_pass++;
    end
    issue_step(4'd5, DA);
    n_checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b0)
      $display("FAIL stall ninth: got valid/ready %b/%b want 0/0", obs_valid, obs_ready);
    else n_pass++;
    sb.push_back(1'b0);
    issue_step(4'd6, DB);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready))
      $display("FAIL stall id6 handshake: got %b/%b want 1/1", obs_valid, obs_ready);
    else if (obs_rob !== exp_rob)
      $display("FAIL stall id6 rob_req: got %b want %b", obs_rob, exp_rob);
    else n_pass++;
    // Retire in the same cycle must not unblock the stalled request yet.
    step(1'b1, 4'd5, DA, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b0)
      $display("FAIL stall same-cycle: got valid/ready %b/%b want 0/0", obs_valid, obs_ready);
    else n_pass++;
    sb.push_back(1'b0);
    issue_step(4'd5, DA);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready))
      $display("FAIL unstall handshake: got %b/%b want 1/1", obs_valid, obs_ready);
    else if (obs_rob !== exp_rob)
      $display("FAIL unstall rob_req: got %b want %b", obs_rob, exp_rob);
    else n_pass++;
    issue_step(4'd5, DA);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL refill stall: got valid %b want 0", obs_valid);
    else n_pass++;
    for (int k = 0; k < 8; k++) retire_step(4'd5, 1'b0);
    retire_step(4'd6, 1'b0);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL stall drain busy_o: got %b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(1'b0);
      issue_step(4'd2, DA);
      exp_rob = sb.pop_front();
      if (!(obs_valid && obs_ready && obs_rob === exp_rob)) begin
        n_checks++;
        $display("FAIL same fill %0d: got %b/%b/%b want 1/1/%b", k, obs_valid, obs_ready,
                 obs_rob, exp_rob);
      end
    end
    // Untagged issue and untagged retire on ID 2: count stays at 4.
    sb.push_back(1'b0);
    step(1'b1, 4'd2, DA, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
      $display("FAIL same id2 issue+retire: got %b/%b/%b want 1/1/%b", obs_valid, obs_ready,
               obs_rob, exp_rob);
    else n_pass++;
    sb.push_back(1'b1);
    issue_step(4'd2, DB);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
      $display("FAIL same id2 to DB: got %b/%b/%b want 1/1/%b", obs_valid, obs_ready,
               obs_rob, exp_rob);
    else n_pass++;
    // Tagged retire on ID 2 alongside an untagged issue on fresh ID 4.
    sb.push_back(1'b0);
    step(1'b1, 4'd4, DA, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
      $display("FAIL same id4 issue: got %b/%b/%b want 1/1/%b", obs_valid, obs_ready,
               obs_rob, exp_rob);
    else n_pass++;
    // rob_cnt[2] is back to 0 and dest stays DA: these bypass; count reaches 8.
    for (int k = 0; k < 4; k++) begin
      sb.push_back(1'b0);
      issue_step(4'd2, DA);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
        $display("FAIL same refill %0d: got %b/%b/%b want 1/1/%b", k, obs_valid, obs_ready,
                 obs_rob, exp_rob);
      else n_pass++;
    end
    issue_step(4'd2, DA);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL same full stall: got valid %b want 0", obs_valid);
    else n_pass++;
    for (int k = 0; k < 8; k++) retire_step(4'd2, 1'b0);
    retire_step(4'd4, 1'b0);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL same drain busy_o: got %b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_burst();
    sb.push_back(1'b0);
    issue_step(4'd1, DA);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
      $display("FAIL burst issue: got %b/%b/%b want 1/1/%b", obs_valid, obs_ready,
               obs_rob, exp_rob);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
      n_checks++;
      if (busy_o !== 1'b1) $display("FAIL burst beat %0d busy_o: got %b want 1", k, busy_o);
      else n_pass++;
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL burst unready last busy_o: got %b want 1", busy_o);
    else n_pass++;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL burst last busy_o: got %b want 0", busy_o);
    else n_pass++;
  endtask

  task automatic test_rebind_reset();
    dest_t d1 [3] = '{DC, DC, DA};
    logic  e1 [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      sb.push_back(e1[k]);
      issue_step(4'd3, d1[k]);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
        $display("FAIL rebind %0d: got %b/%b/%b want 1/1/%b", k, obs_valid, obs_ready,
                 obs_rob, exp_rob);
      else n_pass++;
    end
    // Downstream not ready: valid still passes through, nothing is issued.
    step(1'b1, 4'd6, DA, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_ready !== 1'b0)
      $display("FAIL not-ready: got valid/ready %b/%b want 1/0", obs_valid, obs_ready);
    else n_pass++;
    sb.push_back(1'b0);
    issue_step(4'd7, DB);
    exp_rob = sb.pop_front();
    n_checks++;
    if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
      $display("FAIL pre-reset id7: got %b/%b/%b want 1/1/%b", obs_valid, obs_ready,
               obs_rob, exp_rob);
    else n_pass++;
    ax_id_i   = 4'd7;
    ax_dest_i = DA;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL mid reset busy_o: got %b want 0", busy_o);
    else n_pass++;
    n_checks++;
    if (ax_rob_req_o !== 1'b0) $display("FAIL mid reset rob_req: got %b want 0", ax_rob_req_o);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(1'b0);
      issue_step(4'd3, DA);
      exp_rob = sb.pop_front();
      n_checks++;
      if (!(obs_valid && obs_ready) || obs_rob !== exp_rob)
        $display("FAIL post-reset %0d: got %b/%b/%b want 1/1/%b", k, obs_valid, obs_ready,
                 obs_rob, exp_rob);
      else n_pass++;
    end
    retire_step(4'd3, 1'b0);
    retire_step(4'd3, 1'b0);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL post-reset drain busy_o: got %b want 0", busy_o);
    else n_pass++;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_bypass();
    test_rob_tag();
    test_stall();
    test_same_cycle();
    test_burst();
    test_rebind_reset();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
